fp_add_scheduler: RTL and testbench



---
 rtl/fp_add_scheduler.sv | 267 ++++++++++++++++++++++++++
 tb/tb_fp_add_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_scheduler.sv
// fp_add_scheduler
//   Shares one combinational single-precision adder (floating_unit) among
//   NREQ requesters. A round-robin arbiter picks a requester in IDLE, its
//   operands are captured into op registers, held for SETTLE extra cycles
//   so the adder path may span several clocks, and the sum is registered
//   and offered on the response port until the consumer accepts it.
//
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset
//     req_valid    per-requester request valid            [NREQ]
//     req_ready    per-requester accept, one-hot or zero  [NREQ]
//     req_a/req_b  packed operands, requester i at [32*i+31:32*i]
//     req_sub      per-requester op: 1 = A-B, 0 = A+B      [NREQ]
//     rsp_valid    response valid
//     rsp_ready    consumer accepts response
//     rsp_result   registered single-precision result
//     rsp_id       requester that owns rsp_result          [IDW]
//     busy         high whenever the FSM is not idle
//     rsp_flags    {nan, inf, zero} of rsp_result (only with FP_ADD_FLAGS_EN)
//
//   Build option: define FP_ADD_FLAGS_EN to add the rsp_flags output.

module fp_add_scheduler #(
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int SETTLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*32-1:0]  req_a,
    input  logic [NREQ*32-1:0]  req_b,
    input  logic [NREQ-1:0]     req_sub,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [31:0]         rsp_result,
    output logic [IDW-1:0]      rsp_id,
    output logic                busy
`ifdef FP_ADD_FLAGS_EN
    ,
    output logic [2:0]          rsp_flags
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam int unsigned NREQ_U   = NREQ;
    localparam logic [2:0]  CNT_INIT = 3'(SETTLE);

    state_t          state, state_nxt;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cidx;
    logic            grant_found;
    int unsigned     cand;

    logic [31:0]     op_a, op_b;
    logic            op_sub;
    logic [IDW-1:0]  op_id;
    logic [2:0]      cnt;
    logic [31:0]     fu_result;

    floating_unit u_fu (
        .A      (op_a),
        .B      (op_b),
        .A_S    (op_sub),
        .result (fu_result)
    );

    // Round-robin search: first valid requester at or after ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cidx        = '0;
        for (int unsigned j = 0; j < NREQ_U; j++) begin
            cand = (j + 32'(ptr)) % NREQ_U;
            cidx = IDW'(cand);
            if (!grant_found && req_valid[cidx]) begin
                grant_found = 1'b1;
                grant_idx   = cidx;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_found)  state_nxt = EXEC;
            EXEC:    if (cnt == '0)    state_nxt = RESP;
            RESP:    if (rsp_ready)    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_found) req_ready[grant_idx] = 1'b1;
        busy = (state != IDLE);
    end

    // Datapath registers: operand capture, settle counter, response, pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            op_sub     <= 1'b0;
            op_id      <= '0;
            cnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_id     <= '0;
            ptr        <= '0;
`ifdef FP_ADD_FLAGS_EN
            rsp_flags  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        op_a   <= req_a[32*grant_idx +: 32];
                        op_b   <= req_b[32*grant_idx +: 32];
                        op_sub <= req_sub[grant_idx];
                        op_id  <= grant_idx;
                        cnt    <= CNT_INIT;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        rsp_result <= fu_result;
                        rsp_id     <= op_id;
                        rsp_valid  <= 1'b1;
`ifdef FP_ADD_FLAGS_EN
                        rsp_flags  <= {(fu_result[30:23] == 8'hFF) && (fu_result[22:0] != '0),
                                       (fu_result[30:23] == 8'hFF) && (fu_result[22:0] == '0),
                                       (fu_result[30:23] == '0)    && (fu_result[22:0] == '0)};
`endif
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        // The owner of the response drops to lowest priority.
                        ptr <= (op_id == IDW'(NREQ - 1)) ? '0 : op_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// floating_unit
//   Combinational IEEE-754 single-precision adder/subtractor, round to
//   nearest even, subnormals supported. Invalid operations (NaN input or
//   inf - inf) return the canonical NaN 0xFF800001.
//   Ports: A, B operands; A_S = 1 selects A-B; result is the rounded sum.
module floating_unit (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        A_S,
    output logic [31:0] result
);

    logic        sa, sb, swap, sign_big, eff_sub, sticky, round_up;
    logic        nan_a, nan_b, inf_a, inf_b;
    logic [7:0]  ea, eb, e_big, e_small, d;
    logic [22:0] fa, fb;
    logic [23:0] m_big, m_small;
    logic [26:0] big_ext, small_ext, small_sh, lost, norm;
    logic [27:0] sum;
    logic [4:0]  lz, lshift;
    logic [8:0]  exp_n;
    logic [30:0] packed_res;

    always_comb begin
        sa    = A[31];
        sb    = B[31] ^ A_S;
        ea    = A[30:23];
        eb    = B[30:23];
        fa    = A[22:0];
        fb    = B[22:0];
        nan_a = (ea == 8'hFF) && (fa != '0);
        nan_b = (eb == 8'hFF) && (fb != '0);
        inf_a = (ea == 8'hFF) && (fa == '0);
        inf_b = (eb == 8'hFF) && (fb == '0);

        // Order operands by magnitude so the difference is never negative.
        swap     = (B[30:0] > A[30:0]);
        sign_big = swap ? sb : sa;
        eff_sub  = sa ^ sb;
        e_big    = swap ? eb : ea;
        e_small  = swap ? ea : eb;
        m_big    = swap ? {eb != '0, fb} : {ea != '0, fa};
        m_small  = swap ? {ea != '0, fa} : {eb != '0, fb};
        // Subnormals share the scale of exponent 1.
        if (e_big == '0)   e_big   = 8'd1;
        if (e_small == '0) e_small = 8'd1;
        d = e_big - e_small;

        // 24-bit significand followed by guard, round and sticky bits.
        big_ext   = {m_big, 3'b000};
        small_ext = {m_small, 3'b000};
        lost      = '0;
        if (d >= 8'd27) begin
            small_sh = '0;
            sticky   = |m_small;
        end else begin
            small_sh = small_ext >> d;
            lost     = small_ext << (8'd27 - d);
            sticky   = |lost;
        end
        small_sh[0] = small_sh[0] | sticky;

        sum = eff_sub ? ({1'b0, big_ext} - {1'b0, small_sh})
                      : ({1'b0, big_ext} + {1'b0, small_sh});

        lz = 5'd27;
        for (int unsigned i = 0; i < 27; i++) begin
            if (sum[i]) lz = 5'(26 - i);
        end

        lshift = '0;
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = {1'b0, e_big} + 9'd1;
        end else begin
            // Normalisation may not push the exponent below 1; what is left
            // unnormalised is encoded as a subnormal.
            lshift = ({3'b000, lz} < e_big) ? lz : 5'(e_big - 8'd1);
            norm   = sum[26:0] << lshift;
            exp_n  = {1'b0, e_big} - {4'b0000, lshift};
            if (!norm[26]) exp_n = '0;
        end

        // Adding the round bit into {exponent, fraction} carries naturally
        // into the exponent, including subnormal->normal and max->inf.
        round_up   = norm[2] & (norm[1] | norm[0] | norm[3]);
        packed_res = {exp_n[7:0], norm[25:3]} + {30'b0, round_up};

        if (nan_a || nan_b || (inf_a && inf_b && (sa != sb)))
            result = 32'hFF80_0001;
        else if (inf_a)
            result = {sa, 8'hFF, 23'b0};
        else if (inf_b)
            result = {sb, 8'hFF, 23'b0};
        else if (sum == '0)
            result = {sa & sb, 31'b0};
        else if (exp_n >= 9'd255)
            result = {sign_big, 8'hFF, 23'b0};
        else
            result = {sign_big, packed_res};
    end

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Testbench for fp_add_scheduler: directed vector table, round-robin,
// back-pressure and reset-abort sequences, then randomized traffic checked
// against a real-arithmetic reference and a round-robin priority model.
module tb_fp_add_scheduler;

    localparam int NREQ   = 4;
    localparam int IDW    = 2;
    localparam int SETTLE = 1;
    localparam int PERIOD = 10;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_a, req_b;
    logic [NREQ-1:0]     req_sub;
    logic                rsp_valid, rsp_ready;
    logic [31:0]         rsp_result;
    logic [IDW-1:0]      rsp_id;
    logic                busy;
`ifdef FP_ADD_FLAGS_EN
    logic [2:0]          rsp_flags;
    logic [2:0]          last_flags;
`endif

    logic [31:0] a_arr [NREQ];
    logic [31:0] b_arr [NREQ];
    logic        sub_arr [NREQ];

    int  n_checks = 0;
    int  n_fail   = 0;
    time t_acc;

    always #(PERIOD/2) clk = ~clk;

    always_comb begin
        req_a   = '0;
        req_b   = '0;
        req_sub = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = a_arr[i];
            req_b[32*i +: 32] = b_arr[i];
            req_sub[i]        = sub_arr[i];
        end
    end

    fp_add_scheduler #(.NREQ(NREQ), .IDW(IDW), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sub    (req_sub),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id),
        .busy       (busy)
`ifdef FP_ADD_FLAGS_EN
        ,
        .rsp_flags  (rsp_flags)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // ---------------- reference model ----------------
    function automatic real sp_to_real(input logic [31:0] x);
        real m;
        int  e;
        m = 1.0 + real'(x[22:0]) / 8388608.0;
        e = int'(x[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return x[31] ? -m : m;
    endfunction

    // Round an exactly-representable real to single precision, nearest even.
    function automatic logic [31:0] real_to_sp(input real v);
        logic        s;
        real         m, sc, rem;
        int          e;
        int unsigned q;
        if (v == 0.0) return 32'h0;
        s = (v < 0.0);
        m = s ? -v : v;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        sc  = (m - 1.0) * 8388608.0;
        q   = $rtoi(sc);
        rem = sc - real'(q);
        if (rem > 0.5 || (rem == 0.5 && q[0])) q++;
        if (q == 8388608) begin q = 0; e++; end
        return {s, 8'(e + 127), q[22:0]};
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
        real rb;
        rb = sp_to_real(b);
        return real_to_sp(sp_to_real(a) + (sub ? -rb : rb));
    endfunction

    // Normal operands with nearby exponents keep the double-precision sum exact.
    function automatic logic [31:0] rand_sp();
        logic [31:0] x;
        x[31]    = 1'($urandom_range(0, 1));
        x[30:23] = 8'($urandom_range(115, 135));
        x[22:0]  = 23'($urandom);
        return x;
    endfunction

    // ---------------- transaction driver ----------------
    // Entered and left about 1 time unit after a rising edge with rsp_ready=1.
    task automatic txn(input logic [NREQ-1:0] mask, input bit keep, output int gid,
                       output logic [31:0] res, output int rid, output int lat);
        int w;
        gid = -1; rid = -1; lat = -1; res = '0;
        req_valid = mask;
        #1;
        w = 0;
        while (req_ready == '0 && w < 20) begin @(posedge clk); #2; w++; end
        if (req_ready == '0) begin timeout("grant"); return; end
        chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
        @(posedge clk);
        t_acc = $time;
        #1;
        if (!keep) req_valid[gid] = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("ready_in_exec", 32'(req_ready), 32'd0);
        lat = 0;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        if (!rsp_valid) begin timeout("rsp_valid"); return; end
        res = rsp_result;
        rid = int'(rsp_id);
`ifdef FP_ADD_FLAGS_EN
        last_flags = rsp_flags;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #(PERIOD * 20000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int          gid, rid, lat, w, m_ptr, exp_g;
        logic [31:0] res, exp_r;
        logic [NREQ-1:0] mask;
        bit          seen;
        time         t_prev;

        vecs[0]  = '{0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000}; // 1+2
        vecs[1]  = '{2, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000}; // 3-1
        vecs[2]  = '{1, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000}; // 1-1 -> +0
        vecs[3]  = '{3, 32'h3F000000, 32'h3F000000, 1'b0, 32'h3F800000}; // .5+.5
        vecs[4]  = '{3, 32'h41200000, 32'h41A00000, 1'b1, 32'hC1200000}; // 10-20
        vecs[5]  = '{1, 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000}; // inf+1
        vecs[6]  = '{0, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002}; // subnormals
        vecs[7]  = '{2, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000}; // overflow
        vecs[8]  = '{3, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000}; // tie, even
        vecs[9]  = '{0, 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002}; // tie, odd
        vecs[10] = '{1, 32'h7F800000, 32'hFF800000, 1'b0, 32'hFF800001}; // inf-inf
        vecs[11] = '{2, 32'hC0000000, 32'hBF800000, 1'b0, 32'hC0400000}; // -2+-1

        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = 32'h3F800000; b_arr[i] = 32'h40000000; sub_arr[i] = 1'b0;
        end

        // Reset state
        do_reset();
        chk("rst_rsp_valid",  32'(rsp_valid), 32'd0);
        chk("rst_rsp_result", rsp_result,     32'd0);
        chk("rst_rsp_id",     32'(rsp_id),    32'd0);
        chk("rst_busy",       32'(busy),      32'd0);
        chk("rst_req_ready",  32'(req_ready), 32'd0);

        // Directed vectors, one requester at a time
        foreach (vecs[v]) begin
            a_arr[vecs[v].id]   = vecs[v].a;
            b_arr[vecs[v].id]   = vecs[v].b;
            sub_arr[vecs[v].id] = vecs[v].sub;
            mask = '0;
            mask[vecs[v].id] = 1'b1;
            txn(mask, 1'b0, gid, res, rid, lat);
            chk("vec_grant",   32'(gid), 32'(vecs[v].id));
            chk("vec_rsp_id",  32'(rid), 32'(vecs[v].id));
            chk("vec_result",  res,      vecs[v].exp);
            chk("vec_latency", 32'(lat), 32'(SETTLE + 1));
`ifdef FP_ADD_FLAGS_EN
            chk("vec_flags", 32'(last_flags),
                32'({vecs[v].exp[30:23] == 8'hFF && vecs[v].exp[22:0] != 0,
                     vecs[v].exp[30:23] == 8'hFF && vecs[v].exp[22:0] == 0,
                     vecs[v].exp[30:23] == 0     && vecs[v].exp[22:0] == 0}));
`endif
        end

        // Round robin with all requesters held valid
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = 32'h3F800000; b_arr[i] = 32'h40000000; sub_arr[i] = 1'b0;
        end
        do_reset();
        t_prev = 0;
        for (int k = 0; k < 5; k++) begin
            txn('1, 1'b1, gid, res, rid, lat);
            chk("rr_grant",  32'(gid), 32'(k % NREQ));
            chk("rr_rsp_id", 32'(rid), 32'(k % NREQ));
            chk("rr_result", res,      32'h40400000);
            if (k > 0) chk("rr_interval", 32'(t_acc - t_prev), 32'((SETTLE + 3) * PERIOD));
            t_prev = t_acc;
        end

        // Back-pressure: response held while rsp_ready is low
        rsp_ready = 1'b0;
        req_valid = '1;
        #1;
        chk("bp_grant", 32'(req_ready), 32'b0010);
        @(posedge clk); #1;
        w = 0;
        while (!rsp_valid && w < 20) begin @(posedge clk); #1; w++; end
        if (!rsp_valid) timeout("bp_rsp_valid");
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_valid",  32'(rsp_valid), 32'd1);
            chk("bp_result", rsp_result,     32'h40400000);
            chk("bp_id",     32'(rsp_id),    32'd1);
            chk("bp_ready",  32'(req_ready), 32'd0);
            chk("bp_busy",   32'(busy),      32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        chk("bp_release_busy",  32'(busy),      32'd0);
        chk("bp_next_grant",    32'(req_ready), 32'b0100);

        // Reset during EXEC aborts the operation and restores priority to 0
        @(posedge clk); #1;
        chk("abort_busy_exec", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_busy",      32'(busy),      32'd0);
        chk("abort_grant",     32'(req_ready), 32'b0001);
        req_valid = '0;
        seen = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
        chk("abort_no_rsp", 32'(seen), 32'd0);

        // Randomized traffic against the reference model
        do_reset();
        m_ptr = 0;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                a_arr[i]   = rand_sp();
                b_arr[i]   = rand_sp();
                sub_arr[i] = 1'($urandom_range(0, 1));
            end
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            req_valid = '0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            exp_g = -1;
            for (int j = 0; j < NREQ; j++) begin
                if (exp_g < 0 && mask[(m_ptr + j) % NREQ]) exp_g = (m_ptr + j) % NREQ;
            end
            exp_r = ref_add(a_arr[exp_g], b_arr[exp_g], sub_arr[exp_g]);
            txn(mask, 1'b0, gid, res, rid, lat);
            chk("rnd_grant",   32'(gid), 32'(exp_g));
            chk("rnd_rsp_id",  32'(rid), 32'(exp_g));
            chk("rnd_result",  res,      exp_r);
            chk("rnd_latency", 32'(lat), 32'(SETTLE + 1));
            m_ptr = (exp_g + 1) % NREQ;
        end

        req_valid = '0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
